ex_div: RTL and testbench

- Execute stage of the 5-stage core. It consumes the decoded operation and operands that the decode stage produces, after they pass through the ID/EX register.
- Computes logic, shift and HI/LO-move results for write-back, and executes DIV/DIVU on a 32-iteration radix-2 restoring divider.
- Holds the pipeline with stallreq_o while a divide runs.
- Feeds the EX/MEM register, and forwards wd_o/wreg_o/wdata_o back to decode for bypass.

---
 rtl/ex_div_pkg.sv | 31 +++
 rtl/ex_div_if.sv | 20 ++
 rtl/ex_div_div.sv | 59 +++++
 rtl/ex_div.sv | 49 ++++
 tb/tb_ex_div.sv | 137 +++++++++++++
 5 files changed

// File: rtl/ex_div_pkg.sv
// ex_div_pkg: opcodes, result classes and divider states for the execute stage
package ex_div_pkg;
  localparam int DIV_ITER = 32;
  localparam logic [7:0] EXE_NOP_OP  = 8'b00000000;
  localparam logic [7:0] EXE_AND_OP  = 8'b00100100;
  localparam logic [7:0] EXE_OR_OP   = 8'b00100101;
  localparam logic [7:0] EXE_XOR_OP  = 8'b00100110;
  localparam logic [7:0] EXE_NOR_OP  = 8'b00100111;
  localparam logic [7:0] EXE_SLL_OP  = 8'b01111100;
  localparam logic [7:0] EXE_SRL_OP  = 8'b00000010;
  localparam logic [7:0] EXE_SRA_OP  = 8'b00000011;
  localparam logic [7:0] EXE_MFHI_OP = 8'b00010000;
  localparam logic [7:0] EXE_MFLO_OP = 8'b00010010;
  localparam logic [7:0] EXE_DIV_OP  = 8'b00011010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b00011011;
  localparam logic [2:0] EXE_RES_NOP   = 3'b000;
  localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [2:0] EXE_RES_SHIFT = 3'b010;
  localparam logic [2:0] EXE_RES_MOVE  = 3'b011;
  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  typedef enum logic [1:0] {
    DIV_FREE     = 2'b00,
    DIV_BY_ZERO  = 2'b01,
    DIV_ON       = 2'b10,
    DIV_END      = 2'b11
  } div_state_e;
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic s);
    return (s && v[31]) ? -v : v;
  endfunction
endpackage

// File: rtl/ex_div_if.sv
// ex_div_if: ID/EX inputs and EX/MEM outputs of the execute stage
interface ex_div_if;
  import ex_div_pkg::*;
  logic [7:0] aluop_i;
  logic [2:0] alusel_i;
  logic [31:0] reg1_i, reg2_i, hi_i, lo_i;
  logic [4:0] wd_i;
  logic wreg_i, flush_i;
  logic [4:0] wd_o;
  logic wreg_o, whilo_o, stallreq_o;
  logic [31:0] wdata_o, hi_o, lo_o;
  modport master(
    output aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, hi_i, lo_i, flush_i,
    input wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o
  );
  modport slave(
    input aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, hi_i, lo_i, flush_i,
    output wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o
  );
endinterface

// File: rtl/ex_div_div.sv
// ex_div_div: 32-iteration radix-2 restoring divider with signed correction
module ex_div_div
  import ex_div_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);
  div_state_e state, state_n;
  logic [5:0] cnt;
  logic [64:0] w;
  logic [31:0] dvs, q, r;
  logic [32:0] diff;
  logic neg_q, neg_r;
  // bit 32 of diff is the borrow: partial remainder below divisor
  assign diff = w[64:32] - {1'b0, dvs};
  assign q = w[31:0];
  assign r = w[64:33];
  assign result_o = {neg_r ? -r : r, neg_q ? -q : q};
  assign ready_o = (state == DIV_END) ? DIV_RESULT_READY : DIV_RESULT_NOT_READY;
  // next state: annul aborts from anywhere, END always falls back to FREE
  always_comb begin
    state_n = annul_i ? DIV_FREE :
              state == DIV_FREE ? (start_i ? (opdata2_i == '0 ? DIV_BY_ZERO : DIV_ON) : DIV_FREE) :
              state == DIV_ON ? (cnt == 6'(DIV_ITER - 1) ? DIV_END : DIV_ON) :
              state == DIV_BY_ZERO ? DIV_END : DIV_FREE;
  end
  // state register
  always_ff @(posedge clk) begin
    state <= rst ? DIV_FREE : state_n;
  end
  // operand latch and one shift/subtract step per ON cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      w <= '0;
      dvs <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (state == DIV_FREE && start_i && !annul_i) begin
      cnt <= '0;
      w <= {32'b0, abs32(opdata1_i, signed_div_i), 1'b0};
      dvs <= abs32(opdata2_i, signed_div_i);
      neg_q <= signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
      neg_r <= signed_div_i & opdata1_i[31];
    end else if (state == DIV_ON) begin
      cnt <= cnt + 6'd1;
      w <= diff[32] ? {w[63:0], 1'b0} : {diff[31:0], w[31:0], 1'b1};
    end else if (state == DIV_BY_ZERO) begin
      w <= '0;
    end
  end
endmodule

// File: rtl/ex_div.sv
// ex_div: execute stage with logic/shift/move datapath and iterative divider
module ex_div
  import ex_div_pkg::*;
(
  input logic clk,
  input logic rst,
  ex_div_if.slave bus
);
  logic is_div, ready, start;
  logic [63:0] div_res;
  logic [31:0] logic_res, shift_res, move_res;
  logic [4:0] sh;
  assign is_div = bus.aluop_i == EXE_DIV_OP || bus.aluop_i == EXE_DIVU_OP;
  assign start = is_div & ~bus.flush_i & ~ready;
  assign sh = bus.reg1_i[4:0];
  ex_div_div u_div (
    .clk(clk),
    .rst(rst),
    .signed_div_i(bus.aluop_i == EXE_DIV_OP),
    .opdata1_i(bus.reg1_i),
    .opdata2_i(bus.reg2_i),
    .start_i(start),
    .annul_i(bus.flush_i),
    .result_o(div_res),
    .ready_o(ready)
  );
  // per-class results, then write-back/HI-LO/stall outputs gated by reset and flush
  always_comb begin
    logic_res = bus.aluop_i == EXE_AND_OP ? bus.reg1_i & bus.reg2_i :
                bus.aluop_i == EXE_OR_OP  ? bus.reg1_i | bus.reg2_i :
                bus.aluop_i == EXE_XOR_OP ? bus.reg1_i ^ bus.reg2_i :
                bus.aluop_i == EXE_NOR_OP ? ~(bus.reg1_i | bus.reg2_i) : '0;
    shift_res = bus.aluop_i == EXE_SLL_OP ? bus.reg2_i << sh :
                bus.aluop_i == EXE_SRL_OP ? bus.reg2_i >> sh :
                bus.aluop_i == EXE_SRA_OP ? 32'($signed(bus.reg2_i) >>> sh) : '0;
    move_res = bus.aluop_i == EXE_MFHI_OP ? bus.hi_i :
               bus.aluop_i == EXE_MFLO_OP ? bus.lo_i : '0;
    bus.wd_o = rst ? '0 : bus.wd_i;
    bus.wreg_o = ~rst & bus.wreg_i & ~is_div & ~bus.flush_i;
    bus.wdata_o = (rst || is_div) ? '0 :
                  bus.alusel_i == EXE_RES_LOGIC ? logic_res :
                  bus.alusel_i == EXE_RES_SHIFT ? shift_res :
                  bus.alusel_i == EXE_RES_MOVE  ? move_res : '0;
    bus.whilo_o = ~rst & is_div & ready & ~bus.flush_i;
    bus.hi_o = bus.whilo_o ? div_res[63:32] : '0;
    bus.lo_o = bus.whilo_o ? div_res[31:0] : '0;
    bus.stallreq_o = ~rst & is_div & ~ready & ~bus.flush_i;
  end
endmodule

// File: tb/tb_ex_div.sv
// tb_ex_div: directed checks of the execute stage datapath and divider timing
module tb_ex_div;
  import ex_div_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int passed = 0;
  int total = 0;
  ex_div_if ifc();
  ex_div dut (.clk(clk), .rst(rst), .bus(ifc.slave));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, got, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b);
    ifc.aluop_i = op;
    ifc.alusel_i = sel;
    ifc.reg1_i = a;
    ifc.reg2_i = b;
  endtask

  task automatic run_div(input string tag, input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    drive(op, EXE_RES_NOP, a, b);
    for (int c = 0; c <= 32; c++) begin
      #1;
      chk({tag, "_stall"}, 32'(ifc.stallreq_o), 32'd1);
      chk({tag, "_whilo_early"}, 32'(ifc.whilo_o), 32'd0);
      next_cycle();
    end
    #1;
    chk({tag, "_stall33"}, 32'(ifc.stallreq_o), 32'd0);
    chk({tag, "_whilo33"}, 32'(ifc.whilo_o), 32'd1);
    chk({tag, "_hi"}, ifc.hi_o, exp_hi);
    chk({tag, "_lo"}, ifc.lo_o, exp_lo);
    chk({tag, "_wreg"}, 32'(ifc.wreg_o), 32'd0);
    chk({tag, "_wdata"}, ifc.wdata_o, 32'd0);
    next_cycle();
  endtask

  initial begin
    ifc.flush_i = 1'b0;
    ifc.wd_i = 5'd5;
    ifc.wreg_i = 1'b1;
    ifc.hi_i = 32'hAAAA5555;
    ifc.lo_i = 32'h13572468;
    drive(EXE_OR_OP, EXE_RES_LOGIC, 32'h0000FFFF, 32'h12340000);
    next_cycle();
    next_cycle();
    chk("rst_wdata", ifc.wdata_o, 32'd0);
    chk("rst_wreg", 32'(ifc.wreg_o), 32'd0);
    chk("rst_wd", 32'(ifc.wd_o), 32'd0);
    rst = 1'b0;
    #1;
    chk("or_wdata", ifc.wdata_o, 32'h1234FFFF);
    chk("or_wd", 32'(ifc.wd_o), 32'd5);
    chk("or_wreg", 32'(ifc.wreg_o), 32'd1);
    chk("or_stall", 32'(ifc.stallreq_o), 32'd0);
    drive(EXE_AND_OP, EXE_RES_LOGIC, 32'hF0F0FF00, 32'h0FF0F0F0); #1;
    chk("and", ifc.wdata_o, 32'h00F0F000);
    drive(EXE_XOR_OP, EXE_RES_LOGIC, 32'hF0F0FF00, 32'h0FF0F0F0); #1;
    chk("xor", ifc.wdata_o, 32'hFF000FF0);
    drive(EXE_NOR_OP, EXE_RES_LOGIC, 32'hF0F0FF00, 32'h0FF0F0F0); #1;
    chk("nor", ifc.wdata_o, 32'h00000000 | 32'h000F000F);
    drive(EXE_SRA_OP, EXE_RES_SHIFT, 32'd4, 32'h80000000); #1;
    chk("sra", ifc.wdata_o, 32'hF8000000);
    drive(EXE_SRL_OP, EXE_RES_SHIFT, 32'd4, 32'h80000000); #1;
    chk("srl", ifc.wdata_o, 32'h08000000);
    drive(EXE_SLL_OP, EXE_RES_SHIFT, 32'hFFFFFFE3, 32'h00000005); #1;
    chk("sll_amt_low5", ifc.wdata_o, 32'h00000028);
    drive(EXE_MFHI_OP, EXE_RES_MOVE, 32'd0, 32'd0); #1;
    chk("mfhi", ifc.wdata_o, 32'hAAAA5555);
    drive(EXE_MFLO_OP, EXE_RES_MOVE, 32'd0, 32'd0); #1;
    chk("mflo", ifc.wdata_o, 32'h13572468);
    drive(EXE_OR_OP, 3'b111, 32'hFFFFFFFF, 32'd0); #1;
    chk("bad_sel", ifc.wdata_o, 32'd0);
    ifc.flush_i = 1'b1; #1;
    chk("flush_wreg", 32'(ifc.wreg_o), 32'd0);
    ifc.flush_i = 1'b0;
    next_cycle();
    run_div("divu", EXE_DIVU_OP, 32'd100, 32'd7, 32'h00000002, 32'h0000000E);
    run_div("div_neg", EXE_DIV_OP, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFF2);
    run_div("div_b2b", EXE_DIV_OP, 32'd100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2);
    run_div("divu_big", EXE_DIVU_OP, 32'hFFFFFFFF, 32'h80000001, 32'h7FFFFFFE, 32'h00000001);
    drive(EXE_DIV_OP, EXE_RES_NOP, 32'd1234, 32'd0);
    for (int c = 0; c <= 1; c++) begin
      #1;
      chk("dz_stall", 32'(ifc.stallreq_o), 32'd1);
      chk("dz_whilo_early", 32'(ifc.whilo_o), 32'd0);
      next_cycle();
    end
    #1;
    chk("dz_whilo", 32'(ifc.whilo_o), 32'd1);
    chk("dz_stall2", 32'(ifc.stallreq_o), 32'd0);
    chk("dz_hi", ifc.hi_o, 32'd0);
    chk("dz_lo", ifc.lo_o, 32'd0);
    next_cycle();
    drive(EXE_DIVU_OP, EXE_RES_NOP, 32'd1000, 32'd3);
    for (int c = 0; c < 10; c++) next_cycle();
    ifc.flush_i = 1'b1; #1;
    chk("fl_stall", 32'(ifc.stallreq_o), 32'd0);
    chk("fl_whilo", 32'(ifc.whilo_o), 32'd0);
    chk("fl_wreg", 32'(ifc.wreg_o), 32'd0);
    next_cycle();
    ifc.flush_i = 1'b0;
    run_div("after_flush", EXE_DIVU_OP, 32'd100, 32'd7, 32'h00000002, 32'h0000000E);
    drive(EXE_DIVU_OP, EXE_RES_NOP, 32'd1000, 32'd3);
    for (int c = 0; c < 10; c++) next_cycle();
    rst = 1'b1; #1;
    chk("mr_wdata", ifc.wdata_o, 32'd0);
    chk("mr_wreg", 32'(ifc.wreg_o), 32'd0);
    chk("mr_wd", 32'(ifc.wd_o), 32'd0);
    chk("mr_whilo", 32'(ifc.whilo_o), 32'd0);
    chk("mr_stall", 32'(ifc.stallreq_o), 32'd0);
    chk("mr_hi", ifc.hi_o, 32'd0);
    chk("mr_lo", ifc.lo_o, 32'd0);
    next_cycle();
    rst = 1'b0;
    drive(EXE_NOP_OP, EXE_RES_NOP, 32'd0, 32'd0);
    for (int c = 11; c < 40; c++) begin
      #1;
      chk("mr_no_whilo", 32'(ifc.whilo_o), 32'd0);
      next_cycle();
    end
    run_div("after_rst", EXE_DIVU_OP, 32'd100, 32'd7, 32'h00000002, 32'h0000000E);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
